// File: rtl/instr_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit_pkg
// Description : Shared CPU constants for the fetch path: opcode values,
//               instruction geometry and the fetch state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package instr_fetch_unit_pkg;

  // Instruction geometry: one word is assembled from byte-wide reads
  localparam int unsigned INSTR_WIDTH     = 32;
  localparam int unsigned BYTES_PER_INSTR = 4;

  // Opcode constants (bits 6:0 of an instruction)
  localparam logic [6:0] OPC_HALT   = 7'b0000001;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // Fetch state encoding
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_HALTED = 3'd3,
    ST_FAULT  = 3'd4
  } fetch_state_e;

  // Extract the 7-bit opcode field from an assembled instruction
  function automatic logic [6:0] opcode_of(input logic [INSTR_WIDTH-1:0] instr);
    return instr[6:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Fetches 32-bit instructions as four little-endian byte reads
//               at the PC, presents them to the core for one cycle and feeds
//               the opcode back to the PC. The PC is held (HALT opcode driven)
//               at all times except the single ISSUE cycle. A fetched HALT or
//               a memory timeout parks the unit until reset.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 7,
  parameter logic [6:0]  HALT_OPCODE = OPC_HALT,
  parameter int unsigned TIMEOUT     = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_WIDTH-1:0]  pc_in,
  output logic                   mem_req,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  input  logic                   mem_ack,
  input  logic [7:0]             mem_rdata,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic                   instr_valid,
  output logic [6:0]             opcode_out,
  output logic                   halted,
  output logic                   fault
);

  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT);
  localparam logic [1:0] LAST_BYTE     = 2'(BYTES_PER_INSTR - 1);
  localparam int unsigned SHADOW_WIDTH = INSTR_WIDTH - 8;

  fetch_state_e            state_q, state_d;
  logic [1:0]              byte_idx_q, byte_idx_d;
  logic [7:0]              tmo_q, tmo_d;
  logic [SHADOW_WIDTH-1:0] shadow_q, shadow_d;
  logic [INSTR_WIDTH-1:0]  instr_q, instr_d;
  logic [7:0]              tmo_inc;

  assign tmo_inc = tmo_q + 8'd1;

  // State and datapath registers; reset discards any partially assembled word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      byte_idx_q <= 2'd0;
      tmo_q      <= 8'd0;
      shadow_q   <= '0;
      instr_q    <= '0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      tmo_q      <= tmo_d;
      shadow_q   <= shadow_d;
      instr_q    <= instr_d;
    end
  end

  // Next-state, byte assembly and timeout counting
  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    tmo_d      = tmo_q;
    shadow_d   = shadow_q;
    instr_d    = instr_q;
    case (state_q)
      ST_IDLE: begin
        state_d    = ST_FETCH;
        byte_idx_d = 2'd0;
        tmo_d      = 8'd0;
      end
      ST_FETCH: begin
        if (mem_ack) begin
          // An ack always beats a timeout landing in the same cycle
          tmo_d = 8'd0;
          case (byte_idx_q)
            2'd0:    shadow_d[7:0]   = mem_rdata;
            2'd1:    shadow_d[15:8]  = mem_rdata;
            2'd2:    shadow_d[23:16] = mem_rdata;
            default: instr_d         = {mem_rdata, shadow_q};
          endcase
          if (byte_idx_q == LAST_BYTE) begin
            state_d    = ST_ISSUE;
            byte_idx_d = 2'd0;
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end else begin
          tmo_d = tmo_inc;
          if (tmo_inc == TIMEOUT_LIMIT) begin
            state_d = ST_FAULT;
          end
        end
      end
      ST_ISSUE: begin
        byte_idx_d = 2'd0;
        tmo_d      = 8'd0;
        if (opcode_of(instr_q) == HALT_OPCODE) begin
          state_d = ST_HALTED;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_HALTED: state_d = ST_HALTED;
      ST_FAULT:  state_d = ST_FAULT;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from the state register; the PC is frozen outside ISSUE
  always_comb begin
    mem_req     = 1'b0;
    mem_addr    = '0;
    instr_valid = 1'b0;
    opcode_out  = HALT_OPCODE;
    halted      = 1'b0;
    fault       = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_req  = 1'b1;
        // pc_in is stable here because the PC sees the HALT opcode
        mem_addr = pc_in + ADDR_WIDTH'(byte_idx_q);
      end
      ST_ISSUE: begin
        instr_valid = 1'b1;
        opcode_out  = opcode_of(instr_q);
      end
      ST_HALTED: halted = 1'b1;
      ST_FAULT:  fault  = 1'b1;
      default: ;
    endcase
  end

  assign instr_out = instr_q;

endmodule
`default_nettype wire
